microcode_encoder: RTL and testbench

Decode-stage block that accepts 32-bit RV32I instructions from fetch over a valid/ready handshake and produces the 22-bit microcode word consumed by the per-stage microcode decoders. It also produces register indices, a sign-extended immediate and the PC. It sits between fetch and the S0 dependency/ALU-select logic. Output is registered behind a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`. A synchronous flush drops wrong-path instructions after a taken branch.

---
 rtl/microcode_pkg.sv | 117 +++++++++++
 rtl/microcode_encoder_if.sv | 38 +++
 rtl/microcode_field_encoder.sv | 166 ++++++++++++++++
 rtl/microcode_encoder.sv | 143 ++++++++++++++
 tb/tb_microcode_encoder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/microcode_pkg.sv
// ---------------------------------------------------------------------------
// microcode_pkg
// Shared definitions for the RV32I decode-stage microcode encoder:
//   - microcode word width and bit range of every field
//   - enums for the alu_a / alu_b / cmp / wb / alu_op fields
//   - packed view of the microcode word and of a decoded entry
//   - RV32I major opcodes and the NOP (all-default) word
// ---------------------------------------------------------------------------
package microcode_pkg;

    localparam int MICROCODE_W = 22;

    // Field bit ranges of the microcode word.
    localparam int CHK_RS1_BIT         = 0;
    localparam int CHK_RS2_BIT         = 1;
    localparam int ALU_A_LSB           = 2;
    localparam int ALU_A_MSB           = 3;
    localparam int ALU_B_LSB           = 4;
    localparam int ALU_B_MSB           = 6;
    localparam int CMP_LSB             = 7;
    localparam int CMP_MSB             = 9;
    localparam int MEM_IN_USE_BIT      = 10;
    localparam int ALU_OP_LSB          = 11;
    localparam int ALU_OP_MSB          = 14;
    localparam int MEM_WE_BIT          = 15;
    localparam int ALU_TO_MEM_ADDR_BIT = 16;
    localparam int JUMP_BIT            = 17;
    localparam int WB_LSB              = 18;
    localparam int WB_MSB              = 19;
    localparam int RWE_BIT             = 20;
    localparam int USE_PRE_WB_BIT      = 21;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_e;

    typedef enum logic [2:0] {
        ALU_B_RS2  = 3'd0,
        ALU_B_IMM  = 3'd1,
        ALU_B_FOUR = 3'd2
    } alu_b_e;

    typedef enum logic [2:0] {
        CMP_BEQ    = 3'd0,
        CMP_BNE    = 3'd1,
        CMP_ALWAYS = 3'd2,
        CMP_NEVER  = 3'd3,
        CMP_BLT    = 3'd4,
        CMP_BGE    = 3'd5,
        CMP_BLTU   = 3'd6,
        CMP_BGEU   = 3'd7
    } cmp_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_PC4 = 2'd1
    } wb_e;

    // alu_op = {alt, funct3}
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    // Declared MSB first so the packed layout matches the field ranges above.
    typedef struct packed {
        logic    use_pre_wb;
        logic    reg_write_enable;
        wb_e     wb;
        logic    jump_if_branch;
        logic    alu_out_to_mem_addr;
        logic    mem_write_enable;
        alu_op_e alu_op;
        logic    mem_in_use;
        cmp_e    cmp;
        alu_b_e  alu_b;
        alu_a_e  alu_a;
        logic    check_rs2_dep;
        logic    check_rs1_dep;
    } microcode_t;

    typedef struct packed {
        microcode_t  microcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // All fields zero except cmp = NEVER.
    localparam logic [MICROCODE_W-1:0] NOP_WORD =
        MICROCODE_W'(32'(CMP_NEVER) << CMP_LSB);

endpackage

// File: rtl/microcode_encoder_if.sv
// ---------------------------------------------------------------------------
// microcode_encoder_if
// Fetch-side and S0-side handshake bundle of the microcode encoder.
//   slave  : the encoder (consumes in_*, out_ready; drives in_ready, out_*)
//   master : the environment around it (fetch + S0)
// ---------------------------------------------------------------------------
interface microcode_encoder_if
    import microcode_pkg::*;
#(
    parameter int TAG_W = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_instr;
    logic [31:0]            in_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [MICROCODE_W-1:0] out_microcode;
    logic [4:0]             out_rs1;
    logic [4:0]             out_rs2;
    logic [4:0]             out_rd;
    logic [31:0]            out_imm;
    logic [31:0]            out_pc;
    logic                   out_illegal;
    logic [TAG_W-1:0]       out_tag;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_microcode, out_rs1, out_rs2, out_rd,
               out_imm, out_pc, out_illegal, out_tag
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_microcode, out_rs1, out_rs2, out_rd,
               out_imm, out_pc, out_illegal, out_tag
    );
endinterface

// File: rtl/microcode_field_encoder.sv
// ---------------------------------------------------------------------------
// microcode_field_encoder
// Purely combinational RV32I decode: instruction -> microcode word, register
// indices (zero when the format has no such field), sign-extended immediate
// and illegal flag. Illegal instructions produce the NOP word with all other
// fields zero.
// Ports:
//   instr_i : raw 32-bit instruction
//   dec_o   : decoded entry (microcode, rs1, rs2, rd, imm, illegal)
// Option: MICROCODE_ENC_ILLEGAL_FLAG_EN -- when defined, dec_o.illegal
//         reports illegal instructions; otherwise it is constant 0.
// ---------------------------------------------------------------------------
module microcode_field_encoder
    import microcode_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    microcode_t  mc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned -- otherwise a latch is inferred.
        mc    = microcode_t'(NOP_WORD);
        rs1   = 5'd0;
        rs2   = 5'd0;
        rd    = 5'd0;
        imm   = 32'd0;
        legal = 1'b0;

        // The full 7-bit opcode compare also rejects instr[1:0] != 2'b11.
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                mc.check_rs1_dep    = 1'b1;
                mc.check_rs2_dep    = 1'b1;
                mc.alu_a            = ALU_A_RS1;
                mc.alu_b            = ALU_B_RS2;
                mc.alu_op           = alu_op_e'({funct7[5], funct3});
                mc.reg_write_enable = 1'b1;
                mc.use_pre_wb       = 1'b1;
                rs1 = instr_i[19:15];
                rs2 = instr_i[24:20];
                rd  = instr_i[11:7];
            end
            OPC_OP_IMM: begin
                // Shift-immediates carry funct7 in imm[11:5]; other I-type
                // ALU ops use those bits as immediate, so alt stays 0.
                case (funct3)
                    3'b001:  legal = (funct7 == 7'b0000000);
                    3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                mc.check_rs1_dep    = 1'b1;
                mc.alu_b            = ALU_B_IMM;
                mc.alu_op           = alu_op_e'({(funct3 == 3'b101) & funct7[5], funct3});
                mc.reg_write_enable = 1'b1;
                mc.use_pre_wb       = 1'b1;
                rs1 = instr_i[19:15];
                rd  = instr_i[11:7];
                imm = imm_i;
            end
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1;
                mc.alu_a            = (opcode == OPC_LUI) ? ALU_A_ZERO : ALU_A_PC;
                mc.alu_b            = ALU_B_IMM;
                mc.alu_op           = ALU_ADD;
                mc.reg_write_enable = 1'b1;
                mc.use_pre_wb       = 1'b1;
                rd  = instr_i[11:7];
                imm = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                legal = (opcode == OPC_JAL) || (funct3 == 3'b000);
                mc.check_rs1_dep    = (opcode == OPC_JALR);
                mc.alu_a            = (opcode == OPC_JALR) ? ALU_A_RS1 : ALU_A_PC;
                mc.alu_b            = ALU_B_IMM;
                mc.cmp              = CMP_ALWAYS;
                mc.jump_if_branch   = 1'b1;
                mc.wb               = WB_PC4;
                mc.reg_write_enable = 1'b1;
                mc.use_pre_wb       = 1'b1;
                rs1 = (opcode == OPC_JALR) ? instr_i[19:15] : 5'd0;
                rd  = instr_i[11:7];
                imm = (opcode == OPC_JALR) ? imm_i : imm_j;
            end
            OPC_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                mc.check_rs1_dep  = 1'b1;
                mc.check_rs2_dep  = 1'b1;
                mc.alu_a          = ALU_A_PC;
                mc.alu_b          = ALU_B_IMM;
                mc.cmp            = cmp_e'(funct3);
                mc.jump_if_branch = 1'b1;
                rs1 = instr_i[19:15];
                rs2 = instr_i[24:20];
                imm = imm_b;
            end
            OPC_LOAD: begin
                legal = (funct3 == 3'b010);
                mc.check_rs1_dep       = 1'b1;
                mc.alu_b               = ALU_B_IMM;
                mc.mem_in_use          = 1'b1;
                mc.alu_out_to_mem_addr = 1'b1;
                mc.reg_write_enable    = 1'b1;
                rs1 = instr_i[19:15];
                rd  = instr_i[11:7];
                imm = imm_i;
            end
            OPC_STORE: begin
                legal = (funct3 == 3'b010);
                mc.check_rs1_dep       = 1'b1;
                mc.check_rs2_dep       = 1'b1;
                mc.alu_b               = ALU_B_IMM;
                mc.mem_in_use          = 1'b1;
                mc.mem_write_enable    = 1'b1;
                mc.alu_out_to_mem_addr = 1'b1;
                rs1 = instr_i[19:15];
                rs2 = instr_i[24:20];
                imm = imm_s;
            end
            OPC_MISC_MEM: legal = (funct3 == 3'b000);
            default:      legal = 1'b0;   // SYSTEM and unknown opcodes
        endcase

        if (!legal) begin
            mc  = microcode_t'(NOP_WORD);
            rs1 = 5'd0;
            rs2 = 5'd0;
            rd  = 5'd0;
            imm = 32'd0;
        end
    end

    assign dec_o.microcode = mc;
    assign dec_o.rs1       = rs1;
    assign dec_o.rs2       = rs2;
    assign dec_o.rd        = rd;
    assign dec_o.imm       = imm;
`ifdef MICROCODE_ENC_ILLEGAL_FLAG_EN
    assign dec_o.illegal   = ~legal;
`else
    assign dec_o.illegal   = 1'b0;
`endif

endmodule

// File: rtl/microcode_encoder.sv
// ---------------------------------------------------------------------------
// microcode_encoder
// Decode stage between fetch and S0. Decodes RV32I instructions through
// microcode_field_encoder and registers the result behind a 2-entry skid
// buffer (output register + skid entry), so in_ready is a flop output and
// never depends combinationally on out_ready. A sequence tag counts every
// accepted input; flush drops all buffered and incoming instructions.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (overrides flush)
//   flush : discard buffered and incoming instructions this cycle
//   bus   : microcode_encoder_if.slave (in_* handshake from fetch,
//           out_* handshake and decoded fields to S0)
// Option: MICROCODE_ENC_ILLEGAL_FLAG_EN -- enables out_illegal; when
//         undefined, out_illegal is constant 0.
// ---------------------------------------------------------------------------
module microcode_encoder
    import microcode_pkg::*;
#(
    parameter int TAG_W = 3
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    microcode_encoder_if.slave  bus
);
    dec_t             dec;

    dec_t             out_q,        out_d;
    logic [31:0]      out_pc_q,     out_pc_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;
    logic             out_valid_q,  out_valid_d;

    dec_t             skid_q,       skid_d;
    logic [31:0]      skid_pc_q,    skid_pc_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic             skid_valid_q, skid_valid_d;

    logic             in_ready_q,   in_ready_d;
    logic [TAG_W-1:0] tag_q,        tag_d;

    logic             accept;
    logic             out_free;

    microcode_field_encoder u_field_encoder (
        .instr_i (bus.in_instr),
        .dec_o   (dec)
    );

    assign accept   = bus.in_valid & in_ready_q;
    // Output register can take new data when empty or draining this cycle.
    assign out_free = ~out_valid_q | bus.out_ready;

    always_comb begin
        out_d        = out_q;
        out_pc_d     = out_pc_q;
        out_tag_d    = out_tag_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_tag_d   = skid_tag_q;
        skid_valid_d = skid_valid_q;

        // The tag advances on every handshake, even one dropped by flush.
        tag_d = accept ? tag_q + 1'b1 : tag_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid entry is full, so no input
                // competes with the skid-to-output move.
                out_d        = skid_q;
                out_pc_d     = skid_pc_q;
                out_tag_d    = skid_tag_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_pc_d    = bus.in_pc;
                out_tag_d   = tag_q;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_pc_d    = bus.in_pc;
            skid_tag_d   = tag_q;
            skid_valid_d = 1'b1;
        end

        in_ready_d = ~skid_valid_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of the others regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q.microcode <= microcode_t'(NOP_WORD);
            out_q.rs1       <= 5'd0;
            out_q.rs2       <= 5'd0;
            out_q.rd        <= 5'd0;
            out_q.imm       <= 32'd0;
            out_q.illegal   <= 1'b0;
            out_pc_q        <= 32'd0;
            out_tag_q       <= '0;
            out_valid_q     <= 1'b0;
            skid_valid_q    <= 1'b0;
            in_ready_q      <= 1'b1;
            tag_q           <= '0;
        end else begin
            out_q        <= out_d;
            out_pc_q     <= out_pc_d;
            out_tag_q    <= out_tag_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            tag_q        <= tag_d;
        end
    end

    // NOTE: skid payload is not reset; it is only ever read while
    // skid_valid_q is set, so resetting it would add nothing but fan-out.
    always_ff @(posedge clk) begin
        skid_q     <= skid_d;
        skid_pc_q  <= skid_pc_d;
        skid_tag_q <= skid_tag_d;
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_microcode = out_q.microcode;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_pc        = out_pc_q;
    assign bus.out_illegal   = out_q.illegal;
    assign bus.out_tag       = out_tag_q;

endmodule

// File: tb/tb_microcode_encoder.sv
// ---------------------------------------------------------------------------
// tb_microcode_encoder
// Directed testbench for microcode_encoder: decode vectors with hand-computed
// microcode words, skid-buffer ordering under back-pressure, flush behaviour
// and tag sequencing.
// ---------------------------------------------------------------------------
module tb_microcode_encoder;
    localparam int TAG_W = 3;

`ifdef MICROCODE_ENC_ILLEGAL_FLAG_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] mc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    microcode_encoder_if #(.TAG_W(TAG_W)) bus ();

    microcode_encoder #(.TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic [31:0] mc,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] imm,
                           input logic ill);
        vec_t v;
        v.instr = instr; v.mc = mc; v.rs1 = rs1; v.rs2 = rs2;
        v.rd = rd; v.imm = imm; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = valid;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    initial begin
        //        instr          microcode      rs1 rs2 rd  imm            illegal
        add_vec(32'h002081B3, 32'h0030_0183, 1, 2, 3, 32'h0000_0000, 1'b0); // ADD x3,x1,x2
        add_vec(32'h0080A283, 32'h0011_0591, 1, 0, 5, 32'h0000_0008, 1'b0); // LW x5,8(x1)
        add_vec(32'hFE208EE3, 32'h0002_0017, 1, 2, 0, 32'hFFFF_FFFC, 1'b0); // BEQ x1,x2,-4
        add_vec(32'h00000073, 32'h0000_0180, 0, 0, 0, 32'h0000_0000, ILL ); // ECALL
        add_vec(32'h402081B3, 32'h0030_4183, 1, 2, 3, 32'h0000_0000, 1'b0); // SUB x3,x1,x2
        add_vec(32'h40335293, 32'h0030_6991, 6, 0, 5, 32'h0000_0403, 1'b0); // SRAI x5,x6,3
        add_vec(32'hFFF00093, 32'h0030_0191, 0, 0, 1, 32'hFFFF_FFFF, 1'b0); // ADDI x1,x0,-1
        add_vec(32'h123453B7, 32'h0030_0198, 0, 0, 7, 32'h1234_5000, 1'b0); // LUI x7,0x12345
        add_vec(32'h00001117, 32'h0030_0194, 0, 0, 2, 32'h0000_1000, 1'b0); // AUIPC x2,1
        add_vec(32'h008000EF, 32'h0036_0114, 0, 0, 1, 32'h0000_0008, 1'b0); // JAL x1,+8
        add_vec(32'h00008067, 32'h0036_0111, 1, 0, 0, 32'h0000_0000, 1'b0); // JALR x0,0(x1)
        add_vec(32'h0020A623, 32'h0001_8593, 1, 2, 0, 32'h0000_000C, 1'b0); // SW x2,12(x1)
        add_vec(32'h00008283, 32'h0000_0180, 0, 0, 0, 32'h0000_0000, ILL ); // LB (not LW)
        add_vec(32'h0FF0000F, 32'h0000_0180, 0, 0, 0, 32'h0000_0000, 1'b0); // FENCE
        add_vec(32'h002081B0, 32'h0000_0180, 0, 0, 0, 32'h0000_0000, ILL ); // instr[1:0]=00
        add_vec(32'h0020E863, 32'h0002_0317, 1, 2, 0, 32'h0000_0010, 1'b0); // BLTU x1,x2,+16
        add_vec(32'h0020A863, 32'h0000_0180, 0, 0, 0, 32'h0000_0000, ILL ); // branch f3=010

        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        step();
        step();

        // Reset state
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst microcode", 32'(bus.out_microcode), 32'h180);
        check("rst tag", 32'(bus.out_tag), 32'd0);
        check("rst imm", bus.out_imm, 32'd0);
        check("rst pc", bus.out_pc, 32'd0);
        check("rst rd", 32'(bus.out_rd), 32'd0);
        check("rst illegal", 32'(bus.out_illegal), 32'd0);
        rst = 1'b0;

        // Decode vectors, one at a time with S0 always ready
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].instr, 32'h1000 + 32'(4 * i));
            step();
            drive(1'b0, 32'd0, 32'd0);
            check($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("v%0d microcode", i), 32'(bus.out_microcode), vecs[i].mc);
            check($sformatf("v%0d rs1", i), 32'(bus.out_rs1), 32'(vecs[i].rs1));
            check($sformatf("v%0d rs2", i), 32'(bus.out_rs2), 32'(vecs[i].rs2));
            check($sformatf("v%0d rd", i), 32'(bus.out_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d imm", i), bus.out_imm, vecs[i].imm);
            check($sformatf("v%0d illegal", i), 32'(bus.out_illegal), 32'(vecs[i].ill));
            check($sformatf("v%0d pc", i), bus.out_pc, 32'h1000 + 32'(4 * i));
            check($sformatf("v%0d tag", i), 32'(bus.out_tag), 32'(i % 8));
            step();
            check($sformatf("v%0d drained", i), 32'(bus.out_valid), 32'd0);
        end

        // Skid buffer: stream three instructions against a stalled S0
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h2000);
        step();
        check("skid first valid", 32'(bus.out_valid), 32'd1);
        check("skid first tag", 32'(bus.out_tag), 32'd0);
        check("skid ready after 1", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 32'h0080A283, 32'h2004);
        step();
        check("skid ready after 2", 32'(bus.in_ready), 32'd0);
        check("skid hold tag", 32'(bus.out_tag), 32'd0);
        check("skid hold pc", bus.out_pc, 32'h2000);
        drive(1'b1, 32'h0020A623, 32'h2008);
        step();
        check("skid third blocked", 32'(bus.in_ready), 32'd0);
        check("skid hold microcode", 32'(bus.out_microcode), 32'h300183);
        check("skid hold pc 2", bus.out_pc, 32'h2000);
        bus.out_ready = 1'b1;
        step();
        check("skid drain tag 1", 32'(bus.out_tag), 32'd1);
        check("skid drain mc 1", 32'(bus.out_microcode), 32'h110591);
        check("skid drain pc 1", bus.out_pc, 32'h2004);
        check("skid ready reopens", 32'(bus.in_ready), 32'd1);
        step();
        check("skid drain tag 2", 32'(bus.out_tag), 32'd2);
        check("skid drain mc 2", 32'(bus.out_microcode), 32'h18593);
        check("skid drain pc 2", bus.out_pc, 32'h2008);
        drive(1'b0, 32'd0, 32'd0);
        step();
        check("skid empty", 32'(bus.out_valid), 32'd0);

        // Flush with both entries full and fetch still presenting (tags 3,4 used)
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h3000);
        step();
        drive(1'b1, 32'h0080A283, 32'h3004);
        step();
        check("flush full", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h0020A623, 32'h3008);
        step();
        flush = 1'b0;
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h008000EF, 32'h300C);
        step();
        check("post flush valid", 32'(bus.out_valid), 32'd1);
        check("post flush tag", 32'(bus.out_tag), 32'd5);
        check("post flush mc", 32'(bus.out_microcode), 32'h360114);
        check("post flush pc", bus.out_pc, 32'h300C);

        // Flush coinciding with a handshake: input dropped, tag 6 consumed
        bus.out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h3010);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        check("flush hs out_valid", 32'(bus.out_valid), 32'd0);
        check("flush hs in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("flush hs stays empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h123453B7, 32'h3014);
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("flush hs next tag", 32'(bus.out_tag), 32'd7);
        check("flush hs next pc", bus.out_pc, 32'h3014);

        // Reset overrides flush and clears the tag
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        check("rst>flush valid", 32'(bus.out_valid), 32'd0);
        check("rst>flush microcode", 32'(bus.out_microcode), 32'h180);
        drive(1'b1, 32'h00001117, 32'h4000);
        step();
        drive(1'b0, 32'd0, 32'd0);
        check("rst>flush tag", 32'(bus.out_tag), 32'd0);
        check("rst>flush mc", 32'(bus.out_microcode), 32'h300194);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
